fetch_stage_ctrl: RTL and testbench

//  Instruction-fetch front end; consumer of the pipeline hazard controls (PCWrite, IFIDStall, IFIDFlush).

---
 rtl/fetch_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch front end: owns the PC and the IF/ID register and
// fetches from a variable-latency instruction memory with one request
// outstanding. Stall, flush and PC-freeze come straight from hazard detection.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | out of reset, waiting for start_i
// REQ     | request presented at pc_q (or redirect target), waiting ready
// WAIT    | request accepted, waiting for the response
// HOLD    | response captured in the hold buffer while IF/ID is stalled
module fetch_stage_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            PCWrite_i,
    input  logic            IFIDStall_i,
    input  logic            IFIDFlush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t          state;
    logic            squash;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] target;

    logic            load_en;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_instr;

    // Redirect targets are forced word aligned.
    assign target = branch_target_i & ~XLEN'(3);

    // The request comes straight off the state register; the address
    // follows a same-cycle redirect so a handshake then fetches the target.
    assign imem_req_o  = (state == ST_REQ);
    assign imem_addr_o = (state == ST_REQ && IFIDFlush_i) ? target : pc_q;

    // Pick the instruction (if any) delivered into IF/ID this cycle.
    always_comb begin
        load_en    = 1'b0;
        load_pc    = pc_q;
        load_instr = imem_rdata_i;
        if (!IFIDFlush_i && !IFIDStall_i) begin
            if (state == ST_WAIT && imem_rvalid_i && !squash) begin
                load_en = 1'b1;
            end else if (state == ST_HOLD) begin
                load_en    = 1'b1;
                load_pc    = hold_pc;
                load_instr = hold_instr;
            end
        end
    end

    // Fetch sequencing FSM with squash flag and hold buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            squash     <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready_i) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (squash || IFIDFlush_i) begin
                            squash <= 1'b0;
                            state  <= ST_REQ;
                        end else if (IFIDStall_i) begin
                            hold_pc    <= pc_q;
                            hold_instr <= imem_rdata_i;
                            state      <= ST_HOLD;
                        end else begin
                            state <= ST_REQ;
                        end
                    end else if (IFIDFlush_i) begin
                        squash <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A flush simply abandons the buffered instruction.
                    if (IFIDFlush_i || !IFIDStall_i) state <= ST_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // PC: redirect beats the sequential increment; PCWrite_i gates the +4.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (IFIDFlush_i) begin
            pc_q <= target;
        end else if (load_en && PCWrite_i) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // IF/ID register: flush > stall > load > bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ifid_valid_o <= 1'b0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_INSTR;
        end else if (IFIDFlush_i) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
        end else if (IFIDStall_i) begin
            ifid_valid_o <= ifid_valid_o;
        end else if (load_en) begin
            ifid_valid_o <= 1'b1;
            ifid_pc_o    <= load_pc;
            ifid_instr_o <= load_instr;
        end else begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: a directed vector table, hand-written
// stall/flush/wrap/reset sequences, then random traffic against a
// transaction-level reference model.
module tb_fetch_stage_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, PCWrite_i, IFIDStall_i, IFIDFlush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o, ifid_instr_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_i = ~clk_i;

    fetch_stage_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .PCWrite_i       (PCWrite_i),
        .IFIDStall_i     (IFIDStall_i),
        .IFIDFlush_i     (IFIDFlush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o)
    );

    typedef struct {
        logic        start, ready, rvalid;
        logic [31:0] rdata;
        logic        stall, flush, pcw;
        logic [31:0] tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc, einstr;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic s, input logic r, input logic rv,
                                input logic [31:0] d, input logic st, input logic fl,
                                input logic pw, input logic [31:0] t, input logic er,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.start = s; v.ready = r; v.rvalid = rv; v.rdata = d;
        v.stall = st; v.flush = fl; v.pcw = pw; v.tgt = t;
        v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep; v.einstr = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] epc,
                           input logic [31:0] einstr);
        chk({nm, ".req"}, 32'(imem_req_o), 32'(ereq));
        if (ereq) chk({nm, ".addr"}, imem_addr_o, eaddr);
        chk({nm, ".valid"}, 32'(ifid_valid_o), 32'(evalid));
        if (evalid) chk({nm, ".pc"}, ifid_pc_o, epc);
        chk({nm, ".instr"}, ifid_instr_o, einstr);
    endtask

    task automatic drv(input logic s, input logic r, input logic rv, input logic [31:0] d,
                       input logic st, input logic fl, input logic pw, input logic [31:0] t);
        start_i = s; imem_ready_i = r; imem_rvalid_i = rv; imem_rdata_i = d;
        IFIDStall_i = st; IFIDFlush_i = fl; PCWrite_i = pw; branch_target_i = t;
    endtask

    // Check at the falling edge, then move to just after the next rising edge.
    task automatic step_chk(input string nm, input logic ereq, input logic [31:0] eaddr,
                            input logic evalid, input logic [31:0] epc,
                            input logic [31:0] einstr);
        @(negedge clk_i);
        chk_out(nm, ereq, eaddr, evalid, epc, einstr);
        @(posedge clk_i);
        #1;
    endtask

    // Reference model state: started flag, one outstanding transaction,
    // discard flag, a queue of responses parked during stall, and IF/ID.
    logic        m_started, m_out, m_disc;
    logic [31:0] m_pc;
    logic [63:0] m_held[$];
    logic        m_if_v;
    logic [31:0] m_if_pc, m_if_instr;
    logic        mem_busy;
    int          mem_cnt;

    logic        r_start, r_ready, r_rv, r_stall, r_flush, r_pcw;
    logic [31:0] r_data, r_tgt, tal, e_addr, ld_pc, ld_ins;
    logic        e_req, ld;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(H, L, L, 0,     L, L, H, 0, L, 0, L, 0, NOP);
        vecs[1] = mk(H, H, L, 0,     L, L, H, 0, H, 0, L, 0, NOP);
        vecs[2] = mk(H, L, H, 'hA,   L, L, H, 0, L, 0, L, 0, NOP);
        vecs[3] = mk(H, H, L, 0,     L, L, H, 0, H, 4, H, 0, 'hA);
        vecs[4] = mk(H, L, H, 'hB,   L, L, H, 0, L, 0, L, 0, NOP);
        vecs[5] = mk(H, L, L, 0,     L, L, H, 0, H, 8, H, 4, 'hB);
        vecs[6] = mk(H, L, L, 0,     L, L, H, 0, H, 8, L, 0, NOP);

        rst_i = 1'b1;
        drv(L, L, L, 0, L, L, H, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk_out("reset", L, 0, L, 0, NOP);
        chk("reset.pc", ifid_pc_o, 0);
        chk("reset.addr", imem_addr_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drv(vecs[i].start, vecs[i].ready, vecs[i].rvalid, vecs[i].rdata,
                vecs[i].stall, vecs[i].flush, vecs[i].pcw, vecs[i].tgt);
            step_chk($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr,
                     vecs[i].evalid, vecs[i].epc, vecs[i].einstr);
        end

        // Stall across WAIT and HOLD with PCWrite low.
        drv(H, H, L, 0,    L, L, H, 0); step_chk("s7",        H, 'h8,  L, 0,   NOP);
        drv(H, L, H, 'hC,  L, L, H, 0); step_chk("s8",        L, 0,    L, 0,   NOP);
        drv(H, H, L, 0,    H, L, L, 0); step_chk("stall_hs",  H, 'hC,  H, 'h8, 'hC);
        drv(H, L, L, 0,    H, L, L, 0); step_chk("stall_w",   L, 0,    H, 'h8, 'hC);
        drv(H, L, H, 'hD,  H, L, L, 0); step_chk("stall_rv",  L, 0,    H, 'h8, 'hC);
        drv(H, L, L, 0,    H, L, L, 0); step_chk("hold",      L, 0,    H, 'h8, 'hC);
        drv(H, L, L, 0,    L, L, H, 0); step_chk("release",   L, 0,    H, 'h8, 'hC);
        drv(H, H, L, 0,    L, L, H, 0); step_chk("hold_load", H, 'h10, H, 'hC, 'hD);

        // Flush during WAIT squashes the late response.
        drv(H, L, L, 0,       L, H, H, 'h100); step_chk("flush_w",   L, 0,      L, 0, NOP);
        drv(H, L, H, 'hDEAD,  L, L, H, 0);     step_chk("squash_rv", L, 0,      L, 0, NOP);
        drv(H, H, L, 0,       L, L, H, 0);     step_chk("redirect",  H, 'h100,  L, 0, NOP);
        drv(H, L, H, 'h55,    L, L, H, 0);     step_chk("s18",       L, 0,      L, 0, NOP);

        // Flush with stall in REQ: address switches now, flush wins IF/ID.
        drv(H, L, L, 0, H, H, H, 'h203);
        step_chk("flush_stall", H, 'h200, H, 'h100, 'h55);

        // Redirect with handshake in the same cycle, then PC wrap.
        drv(H, H, L, 0,    L, H, H, 32'hFFFF_FFFC);
        step_chk("wrap_hs", H, 32'hFFFF_FFFC, L, 0, NOP);
        drv(H, L, H, 'h77, L, L, H, 0); step_chk("wrap_rv",   L, 0, L, 0, NOP);
        drv(H, H, L, 0,    L, L, H, 0); step_chk("wrap_addr", H, 0, H, 32'hFFFF_FFFC, 'h77);

        // Async reset while WAIT, then a stray response must be ignored.
        drv(H, L, L, 0, L, L, H, 0);
        rst_i = 1'b1;
        #2;
        chk_out("async_rst", L, 0, L, 0, NOP);
        chk("async_rst.pc", ifid_pc_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drv(L, L, H, 'hBAD, L, L, H, 0); step_chk("stray_rv",   L, 0, L, 0, NOP);
        drv(H, L, L, 0,     L, L, H, 0); step_chk("idle_after", L, 0, L, 0, NOP);
        drv(H, L, L, 0,     L, L, H, 0); step_chk("restart",    H, 0, L, 0, NOP);

        // Random traffic against the reference model.
        rst_i = 1'b1;
        drv(L, L, L, 0, L, L, H, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_started = L; m_out = L; m_disc = L; m_pc = 0; m_held.delete();
        m_if_v = L; m_if_pc = 0; m_if_instr = NOP;
        mem_busy = L; mem_cnt = 0;

        for (int c = 0; c < 3000; c++) begin
            r_rv    = mem_busy && (mem_cnt == 0);
            r_data  = r_rv ? $urandom : 32'd0;
            r_start = (c >= 4) ? H : ($urandom_range(0, 3) == 0);
            r_ready = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_flush = ($urandom_range(0, 11) == 0);
            r_pcw   = ($urandom_range(0, 7) != 0);
            r_tgt   = $urandom;
            drv(r_start, r_ready, r_rv, r_data, r_stall, r_flush, r_pcw, r_tgt);

            tal    = r_tgt & ~32'd3;
            e_req  = m_started && !m_out && (m_held.size() == 0);
            e_addr = (e_req && r_flush) ? tal : m_pc;

            @(negedge clk_i);
            chk_out($sformatf("rnd%0d", c), e_req, e_addr, m_if_v, m_if_pc, m_if_instr);

            ld = L; ld_pc = 0; ld_ins = 0;
            if (m_held.size() != 0) begin
                if (r_flush) m_held.delete();
                else if (!r_stall) begin
                    ld = H;
                    {ld_pc, ld_ins} = m_held.pop_front();
                end
            end else if (m_out && r_rv) begin
                m_out = L;
                if (m_disc || r_flush) m_disc = L;
                else if (r_stall) m_held.push_back({m_pc, r_data});
                else begin
                    ld = H; ld_pc = m_pc; ld_ins = r_data;
                end
            end else if (m_out && r_flush) begin
                m_disc = H;
            end
            if (e_req && r_ready) m_out = H;
            if (ld && r_pcw) m_pc = m_pc + 32'd4;
            if (r_flush) m_pc = tal;
            if (r_start) m_started = H;
            if (r_flush) begin
                m_if_v = L; m_if_instr = NOP;
            end else if (!r_stall) begin
                if (ld) begin
                    m_if_v = H; m_if_pc = ld_pc; m_if_instr = ld_ins;
                end else begin
                    m_if_v = L; m_if_instr = NOP;
                end
            end

            if (r_rv) mem_busy = L;
            else if (mem_busy) mem_cnt--;
            if (imem_req_o && r_ready) begin
                mem_busy = H;
                mem_cnt  = $urandom_range(0, 3);
            end

            @(posedge clk_i);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
